// File: rtl/calc_seq_ctrl_pkg.sv
// Shared types for the calculator sequencer: operation codes, FSM states and
// the error pattern shown on the display.
package calc_pkg;

  typedef enum logic [2:0] {
    FUNC_ADD  = 3'd0,
    FUNC_SUB  = 3'd1,
    FUNC_MUL  = 3'd2,
    FUNC_DIV  = 3'd3,
    FUNC_AND  = 3'd4,
    FUNC_OR   = 3'd5,
    FUNC_XOR  = 3'd6,
    FUNC_RSVD = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_LATCH   = 3'd4,
    S_SHOW    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  localparam logic [31:0] ERR_PAT_DEFAULT = 32'hEEEE_EEEE;

  // Operations the datapath must never see: reserved code or a zero divisor.
  function automatic logic op_rejected(input logic [2:0] f, input logic divisor_zero);
    return (f == FUNC_RSVD) || ((f == FUNC_DIV) && divisor_zero);
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Start/done handshake between the sequencer (master) and the arithmetic
// datapath (slave), carrying the registered operands and the result.
interface calc_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 32
);
  logic              op_start;
  logic [2:0]        op_func;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_done;
  logic [RES_W-1:0]  op_result;

  modport master (
    output op_start, op_func, op_a, op_b,
    input  op_done, op_result
  );

  modport slave (
    input  op_start, op_func, op_a, op_b,
    output op_done, op_result
  );
endinterface

// File: rtl/calc_btn_edge.sv
// Rising-edge detector for the debounced button; the press pulse is registered
// so it is exactly one clock wide and glitch-free for the FSM.
module calc_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  logic btn_reg;
  logic press_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_reg   <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      btn_reg   <= button;
      press_reg <= button & ~btn_reg;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Button-driven sequencer: captures operands, issues one datapath operation,
// waits for completion with a timeout and holds the result for the display.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int              DATA_W  = 8,
  parameter int              RES_W   = 32,
  parameter int              TIMEOUT = 64,
  parameter logic [RES_W-1:0] ERR_PAT = RES_W'(ERR_PAT_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              button,
  input  logic [2:0]        func,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  calc_seq_ctrl_if.master   dp,
  output logic [RES_W-1:0]  cal_result,
  output logic              result_valid,
  output logic              err,
  output logic              busy,
  output logic              disp_on
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Exit compares the pre-increment value so the WAIT count never reaches TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  logic press;

  calc_btn_edge u_btn_edge (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .press  (press)
  );

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [2:0]        func_reg, func_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [RES_W-1:0]  res_reg, res_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;
  logic              disp_reg, disp_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      func_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      disp_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      func_reg  <= func_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      disp_reg  <= disp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    func_next  = func_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    disp_next  = disp_reg;

    unique case (state_reg)
      S_IDLE, S_SHOW, S_ERR: begin
        if (press) begin
          state_next = S_CAPTURE;
          valid_next = 1'b0;
          err_next   = 1'b0;
          disp_next  = 1'b0;
        end
      end
      S_CAPTURE: begin
        func_next = func;
        a_next    = num1;
        b_next    = num2;
        if (op_rejected(func, num2 == '0)) begin
          state_next = S_ERR;
          res_next   = ERR_PAT;
          err_next   = 1'b1;
          disp_next  = 1'b1;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (dp.op_done) begin
          state_next = S_LATCH;
          res_next   = dp.op_result;
          valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            state_next = S_ERR;
            res_next   = ERR_PAT;
            err_next   = 1'b1;
            disp_next  = 1'b1;
          end
        end
      end
      S_LATCH: begin
        state_next = S_SHOW;
        disp_next  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    // Unstable clock: park everything at reset values and ignore the button.
    if (!locked) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      func_next  = '0;
      a_next     = '0;
      b_next     = '0;
      res_next   = '0;
      valid_next = 1'b0;
      err_next   = 1'b0;
      disp_next  = 1'b0;
    end
  end

  assign dp.op_start  = (state_reg == S_ISSUE);
  assign dp.op_func   = func_reg;
  assign dp.op_a      = a_reg;
  assign dp.op_b      = b_reg;
  assign cal_result   = res_reg;
  assign result_valid = valid_reg;
  assign err          = err_reg;
  assign disp_on      = disp_reg;
  assign busy         = (state_reg == S_CAPTURE) || (state_reg == S_ISSUE) ||
                        (state_reg == S_WAIT);

endmodule
